// File: rtl/mult_share_seq.sv
// mult_share_seq: two-port arbiter and sequencer for the shared shift-add multiplier datapath.
// Define MULT_SHARE_RR_EN for round-robin tie breaking; otherwise requester 0 wins ties.
module mult_share_seq #(
  parameter int NBITS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               req,
  input  logic                     dp_p0,
  output logic [1:0]               gnt,
  output logic                     busy,
  output logic                     done,
  output logic                     done_id,
  output logic                     dp_sel,
  output logic                     dp_load,
  output logic                     dp_add,
  output logic                     dp_write,
  output logic                     dp_shft,
  output logic [$clog2(NBITS):0]   bit_cnt
);
  localparam int CW = $clog2(NBITS) + 1;
  localparam logic [CW-1:0] LAST = CW'(NBITS);
`ifdef MULT_SHARE_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ADD, S_SHIFT, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt_inc;
  logic          r_sel, r_last, r_done_id, w_win;

  assign w_cnt_inc = r_cnt + CW'(1);
  // Requester 1 wins alone, or on a tie when round-robin says it is its turn.
  assign w_win = req[1] & (~req[0] | (RR & ~r_last));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_sel     <= 1'b0;
      r_last    <= 1'b1;
      r_done_id <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= r_state == S_LOAD ? '0 : r_state == S_SHIFT ? w_cnt_inc : r_cnt;
      r_sel     <= (r_state == S_IDLE && |req) ? w_win : r_sel;
      r_done_id <= (r_state == S_SHIFT && w_next == S_DONE) ? r_sel : r_done_id;
      r_last    <= r_state == S_DONE ? r_sel : r_last;
    end
  end

  always_comb begin
    w_next = r_state == S_IDLE  ? (|req ? S_LOAD : S_IDLE) :
             r_state == S_LOAD  ? S_ADD :
             r_state == S_ADD   ? S_SHIFT :
             r_state == S_SHIFT ? (w_cnt_inc == LAST ? S_DONE : S_ADD) :
                                  S_IDLE;
  end

  always_comb begin
    busy     = r_state != S_IDLE;
    gnt      = busy ? (r_sel ? 2'b10 : 2'b01) : 2'b00;
    dp_sel   = r_sel;
    dp_load  = r_state == S_LOAD;
    dp_add   = r_state == S_ADD && dp_p0;
    dp_write = r_state == S_ADD && dp_p0;
    dp_shft  = r_state == S_SHIFT;
    done     = r_state == S_DONE;
    done_id  = r_done_id;
    bit_cnt  = r_cnt;
  end
endmodule

// File: tb/tb_mult_share_seq.sv
// tb_mult_share_seq: directed self-checking bench for mult_share_seq.
module tb_mult_share_seq;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic       dp_p0 = 1'b0;
  logic [1:0] gnt;
  logic       busy, done, done_id, dp_sel, dp_load, dp_add, dp_write, dp_shft;
  logic [4:0] bit_cnt;

  int checks = 0;
  int errors = 0;
  int cyc, n_add, n_shft, bad;
  logic [15:0] m_op;
  int         load_cyc[$];
  logic [1:0] load_gnt[$];
  int         done_cyc[$];
  logic       done_idq[$];

  mult_share_seq #(.NBITS(16)) dut (
    .clk(clk), .reset(reset), .req(req), .dp_p0(dp_p0), .gnt(gnt), .busy(busy),
    .done(done), .done_id(done_id), .dp_sel(dp_sel), .dp_load(dp_load),
    .dp_add(dp_add), .dp_write(dp_write), .dp_shft(dp_shft), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  // Advance one cycle, model the product LSB as multiplier bit bit_cnt, and log activity.
  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
    dp_p0 = (bit_cnt < 5'd16) ? m_op[bit_cnt[3:0]] : 1'b0;
    #1;
    n_add  += int'(dp_add);
    n_shft += int'(dp_shft);
    if (dp_add !== dp_write) bad++;
    if (int'(dp_load) + int'(dp_add) + int'(dp_shft) + int'(done) > 1) bad++;
    if (dp_load) begin
      load_cyc.push_back(cyc);
      load_gnt.push_back(gnt);
    end
    if (done) begin
      done_cyc.push_back(cyc);
      done_idq.push_back(done_id);
    end
  endtask

  task automatic clear_log;
    cyc = 0; n_add = 0; n_shft = 0; bad = 0;
    load_cyc.delete(); load_gnt.delete(); done_cyc.delete(); done_idq.delete();
  endtask

  task automatic test_reset;
    clear_log();
    m_op = 16'h0000;
    reset = 1'b1;
    req = 2'b00;
    repeat (3) step();
    checks++;
    if ({gnt, busy, done, done_id, dp_sel, dp_load, dp_add, dp_write, dp_shft, bit_cnt} !== 15'd0)
      begin errors++; $display("FAIL reset_outputs: got %b, want all zero",
        {gnt, busy, done, done_id, dp_sel, dp_load, dp_add, dp_write, dp_shft, bit_cnt}); end
    reset = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || gnt !== 2'b00)
      begin errors++; $display("FAIL reset_idle: busy=%b gnt=%b, want 0 00", busy, gnt); end
  endtask

  task automatic test_single;
    clear_log();
    m_op = 16'h0000;
    req = 2'b01;
    step();
    checks++;
    if (gnt !== 2'b01 || dp_load !== 1'b1 || busy !== 1'b1)
      begin errors++; $display("FAIL single_load: gnt=%b load=%b busy=%b, want 01 1 1", gnt, dp_load, busy); end
    req = 2'b00;
    repeat (33) step();
    checks++;
    if (done !== 1'b1 || done_id !== 1'b0 || cyc != 34)
      begin errors++; $display("FAIL single_done: done=%b id=%b cyc=%0d, want 1 0 34", done, done_id, cyc); end
    step();
    checks++;
    if ({busy, gnt, dp_load, dp_add, dp_write, dp_shft, done} !== 8'd0)
      begin errors++; $display("FAIL single_idle: got %b, want 00000000",
        {busy, gnt, dp_load, dp_add, dp_write, dp_shft, done}); end
  endtask

  task automatic test_a5a5;
    int bc_bad;
    clear_log();
    bc_bad = 0;
    m_op = 16'hA5A5;
    req = 2'b01;
    step();
    req = 2'b00;
    for (int k = 0; k < 16; k++) begin
      step();
      if (bit_cnt !== 5'(k)) bc_bad++;
      step();
    end
    step();
    checks++;
    if (n_add != 8)
      begin errors++; $display("FAIL a5a5_adds: got %0d, want 8", n_add); end
    checks++;
    if (n_shft != 16)
      begin errors++; $display("FAIL a5a5_shifts: got %0d, want 16", n_shft); end
    checks++;
    if (done !== 1'b1 || bit_cnt !== 5'd16 || cyc != 34)
      begin errors++; $display("FAIL a5a5_done: done=%b bit_cnt=%0d cyc=%0d, want 1 16 34", done, bit_cnt, cyc); end
    checks++;
    if (bad != 0 || bc_bad != 0)
      begin errors++; $display("FAIL a5a5_strobes: exclusivity errs=%0d bit_cnt errs=%0d, want 0 0", bad, bc_bad); end
    step();
  endtask

  task automatic test_tie;
    logic [1:0] eg [3];
    logic       eid [3];
`ifdef MULT_SHARE_RR_EN
    eg = '{2'b01, 2'b10, 2'b01};
    eid = '{1'b0, 1'b1, 1'b0};
`else
    eg = '{2'b01, 2'b01, 2'b01};
    eid = '{1'b0, 1'b0, 1'b0};
`endif
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_log();
    m_op = 16'h1234;
    req = 2'b11;
    repeat (72) step();
    req = 2'b00;
    repeat (40) step();
    checks++;
    if (load_cyc.size() != 3 || done_cyc.size() != 3)
      begin errors++; $display("FAIL tie_count: loads=%0d dones=%0d, want 3 3", load_cyc.size(), done_cyc.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (load_gnt[i] !== eg[i] || load_cyc[i] != 1 + 35 * i || done_cyc[i] != 34 + 35 * i || done_idq[i] !== eid[i])
          begin errors++; $display("FAIL tie_op%0d: gnt=%b load@%0d done@%0d id=%b, want %b %0d %0d %b", i,
            load_gnt[i], load_cyc[i], done_cyc[i], done_idq[i], eg[i], 1 + 35 * i, 34 + 35 * i, eid[i]); end
      end
    end
  endtask

  task automatic test_reset_mid;
    clear_log();
    m_op = 16'hFFFF;
    req = 2'b01;
    repeat (20) step();
    reset = 1'b1;
    step();
    checks++;
    if ({gnt, busy, done, done_id, dp_sel, dp_load, dp_add, dp_write, dp_shft, bit_cnt} !== 15'd0)
      begin errors++; $display("FAIL midreset_outputs: got %b, want all zero",
        {gnt, busy, done, done_id, dp_sel, dp_load, dp_add, dp_write, dp_shft, bit_cnt}); end
    reset = 1'b0;
    req = 2'b00;
    repeat (5) step();
    checks++;
    if (done_cyc.size() != 0)
      begin errors++; $display("FAIL midreset_nodone: got %0d done pulses, want 0", done_cyc.size()); end
    clear_log();
    req = 2'b10;
    step();
    repeat (33) step();
    checks++;
    if (done !== 1'b1 || done_id !== 1'b1 || load_gnt.size() != 1 || load_gnt[0] !== 2'b10)
      begin errors++; $display("FAIL midreset_fresh: done=%b id=%b loads=%0d, want 1 1 1", done, done_id, load_gnt.size()); end
    req = 2'b00;
    step();
  endtask

  task automatic test_drop;
    clear_log();
    m_op = 16'h00FF;
    req = 2'b01;
    repeat (5) step();
    req = 2'b00;
    repeat (29) step();
    checks++;
    if (done !== 1'b1 || done_id !== 1'b0 || cyc != 34)
      begin errors++; $display("FAIL drop_done: done=%b id=%b cyc=%0d, want 1 0 34", done, done_id, cyc); end
    repeat (10) step();
    checks++;
    if (load_cyc.size() != 1 || busy !== 1'b0)
      begin errors++; $display("FAIL drop_nogrant: loads=%0d busy=%b, want 1 0", load_cyc.size(), busy); end
  endtask

  task automatic test_back_to_back;
    clear_log();
    m_op = 16'h8001;
    req = 2'b10;
    step();
    checks++;
    if (gnt !== 2'b10 || dp_sel !== 1'b1)
      begin errors++; $display("FAIL b2b_first: gnt=%b sel=%b, want 10 1", gnt, dp_sel); end
    repeat (9) step();
    req = 2'b11;
    repeat (24) step();
    req = 2'b01;
    repeat (2) step();
    checks++;
    if (load_cyc.size() != 2 || load_cyc[1] != 36 || load_gnt[1] !== 2'b01 || done_idq.size() != 1 || done_idq[0] !== 1'b1)
      begin errors++; $display("FAIL b2b_second: loads=%0d second@%0d gnt=%b, want 2 36 01",
        load_cyc.size(), load_cyc.size() > 1 ? load_cyc[1] : -1, load_gnt.size() > 1 ? load_gnt[1] : 2'bxx); end
    repeat (33) step();
    checks++;
    if (done !== 1'b1 || done_id !== 1'b0 || cyc != 69)
      begin errors++; $display("FAIL b2b_done: done=%b id=%b cyc=%0d, want 1 0 69", done, done_id, cyc); end
    req = 2'b00;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_a5a5();
    test_tie();
    test_reset_mid();
    test_drop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_share_seq.md
# mult_share_seq

Sequencer and two-port arbiter for the 16x16 shift-add multiplier datapath. It grants the single datapath to one of two requesters and selects that requester's operands through the datapath input mux (`dp_sel`). It then steps the datapath through load, 16 conditional add cycles and 16 shift cycles, and signals completion with a one-cycle `done` pulse tagged with the requester id. It sits between the requesting units and the datapath, replacing per-user free-running control.

## Interface
Parameters:
- `NBITS`, default 16: multiplier width, equal to the number of add/shift iterations. The counter width is clog2(NBITS)+1.

Ports:
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high reset.
- `req`  in  2: level requests, one per requester. A requester holds its bit high until it sees its `done`.
- `dp_p0`  in  1: LSB of the datapath product register.
- `gnt`  out  2: one-hot grant, asserted in states LOAD through DONE.
- `busy`  out  1: high whenever the state is not IDLE.
- `done`  out  1: one-cycle pulse in state DONE.
- `done_id`  out  1: id of the finished requester. Valid with `done`. Holds its value otherwise.
- `dp_sel`  out  1: operand mux select, equal to the granted id. Stable from LOAD through DONE.
- `dp_load`  out  1: loads the operands and clears the product register.
- `dp_add`  out  1: adds the multiplicand into the upper product half.
- `dp_write`  out  1: writes the adder result into the product register.
- `dp_shft`  out  1: shifts the product register right by 1.
- `bit_cnt`  out  clog2(NBITS)+1: number of completed shifts.

## Operation
- States: IDLE, LOAD, ADD, SHIFT, DONE.
- IDLE: if `req` is nonzero, arbitrate, latch the winner into `sel_q` and go to LOAD. Otherwise stay in IDLE.
- LOAD: assert `dp_load`, clear `bit_cnt`, go to ADD.
- ADD: if `dp_p0`=1, assert `dp_add` and `dp_write` together; otherwise assert neither. Go to SHIFT. `dp_p0` is sampled only in this state.
- SHIFT: assert `dp_shft` and increment `bit_cnt`. If the incremented value equals NBITS, go to DONE; otherwise go to ADD.
- DONE: assert `done`, drive `done_id`=`sel_q`, update the round-robin pointer `last_q`=`sel_q`, go to IDLE.
- Arbitration with a single request: the requesting bit wins.
- Arbitration with both requests high: the winner is `~last_q`.
- `last_q` resets to 1, so requester 0 wins the first tie.
- Dropping `req` mid-operation is ignored. The operation completes and `done` still pulses.
- A `req` bit that is still high in the IDLE cycle after DONE is treated as a new request.
- All datapath strobes are mutually exclusive, except `dp_add` and `dp_write`, which are asserted together.
- All outputs are registered-state decodes. No output depends combinationally on `req`.

## Timing
- Reset values: state=IDLE; `gnt`=00; `busy`, `done`, `done_id`, `dp_sel`, `dp_load`, `dp_add`, `dp_write`, `dp_shft` all 0; `bit_cnt`=0; `last_q`=1.
- Reset has priority over every transition, including mid-operation. The next cycle is IDLE with all outputs at their reset values, and the interrupted requester gets no `done`.
- Cycle numbering: edge E0 samples `req` in IDLE.
  - Cycle 1: LOAD.
  - Cycles 2,4,...,32: ADD.
  - Cycles 3,5,...,33: SHIFT.
  - Cycle 34: DONE.
  - Cycle 35: IDLE.
- Latency is a fixed 34 cycles from the grant edge to `done`, independent of operand values.
- Back-to-back service: the earliest next LOAD is cycle 36. Sustained throughput is one product per 35 cycles.
- `bit_cnt` reads k during the ADD state of iteration k+1, and NBITS during DONE.

## Configuration
- `MULT_SHARE_RR_EN` defined: round-robin arbitration as described in Operation.
- `MULT_SHARE_RR_EN` undefined: fixed priority; requester 0 always wins a tie. `last_q` is still tracked but never affects the grant.

## Test plan
- Reset in IDLE, then `req`=01 held for one cycle → `gnt`=01 and `dp_load`=1 in cycle 1; `done`=1 with `done_id`=0 in cycle 34; all strobes and `busy` 0 in cycle 35.
- Grant to requester 0, drive `dp_p0` = LSB of 0xA5A5 shifted each iteration → `dp_add`/`dp_write` asserted exactly in the 8 ADD cycles where `dp_p0`=1; exactly 16 `dp_shft` pulses; `bit_cnt`=16 at DONE.
- `req`=11 from reset and held → grants alternate 0,1,0 with `MULT_SHARE_RR_EN`; grants 0,0,0 without it. Consecutive LOADs are 35 cycles apart.
- `reset` asserted in cycle 20 of an operation → next cycle IDLE with all outputs 0 and no `done`; a fresh `req`=10 then completes 34 cycles after its grant with `done_id`=1.
- `req`=01 dropped in cycle 5 → operation still ends with `done`=1, `done_id`=0 in cycle 34; no new grant follows.
- `req`=10 in IDLE, then `req[0]` raised in cycle 10 → requester 0 is granted only after requester 1's DONE, with LOAD in cycle 36.
